// File: rtl/nnrv_id_pkg.sv
// nnrv_id_pkg: opcodes, ALU op codes, branch funct3 codes and the decoded control bundle of the ID stage
package nnrv_id_pkg;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;
  typedef struct packed {
    logic       valid;
    alu_op_e    alu_op;
    logic       src_imm;
    logic       src_pc;
    logic       link;
    logic [2:0] funct3;
    logic       mem_rd;
    logic       mem_wr;
    logic [4:0] rd_addr;
    logic       rd_wen;
  } ctrl_t;
  function automatic alu_op_e alu_map(input logic [2:0] f3, input logic alt);
    return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD) :
           f3 == 3'd1 ? ALU_SLL :
           f3 == 3'd2 ? ALU_SLT :
           f3 == 3'd3 ? ALU_SLTU :
           f3 == 3'd4 ? ALU_XOR :
           f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) :
           f3 == 3'd6 ? ALU_OR : ALU_AND;
  endfunction
  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t c;
    logic [6:0] op;
    op = ins[6:0];
    c = '0;
    c.valid = op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                         OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
    c.alu_op = op == OPC_OP ? alu_map(ins[14:12], ins[30]) :
               op == OPC_OP_IMM ? alu_map(ins[14:12], ins[30] && ins[14:12] == 3'd5) :
               op == OPC_LUI ? ALU_PASSB :
               op == OPC_BRANCH ? ALU_SUB : ALU_ADD;
    c.src_imm = c.valid && op != OPC_OP && op != OPC_BRANCH;
    c.src_pc = op == OPC_AUIPC;
    c.link = op == OPC_JAL || op == OPC_JALR;
    c.funct3 = ins[14:12];
    c.mem_rd = op == OPC_LOAD;
    c.mem_wr = op == OPC_STORE;
    c.rd_addr = ins[11:7];
    c.rd_wen = op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR}
               && ins[11:7] != 5'd0;
    return c;
  endfunction
endpackage

// File: rtl/nnrv_id_imm_gen.sv
// nnrv_imm_gen: instr -> sign-extended I/S/B/U/J immediate selected by opcode (combinational)
module nnrv_imm_gen
  import nnrv_id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  logic [6:0]  op;
  logic [31:0] imm32;
  assign op = instr[6:0];
  always_comb
    imm32 = op == OPC_STORE ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            op == OPC_BRANCH ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
            op inside {OPC_LUI, OPC_AUIPC} ? {instr[31:12], 12'b0} :
            op == OPC_JAL ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
            {{20{instr[31]}}, instr[31:20]};
  assign imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
endmodule

// File: rtl/nnrv_id.sv
// nnrv_id: RV32I decode stage; regfile read + EX/MEM forwarding, load-use stall, jump/branch redirect to fetch, registered EX bundle
module nnrv_id
  import nnrv_id_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int XLEN        = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INSTR_WIDTH-1:0] i_if_instr,
  input  logic [XLEN-1:0]        i_if_cur_pc,
  output logic                   o_if_jmp_stall,
  output logic [XLEN-1:0]        o_if_jmp_pc,
  output logic                   o_if_hazard_stall,
  output logic [4:0]             o_rf_rs1_addr,
  output logic [4:0]             o_rf_rs2_addr,
  input  logic [XLEN-1:0]        i_rf_rs1_data,
  input  logic [XLEN-1:0]        i_rf_rs2_data,
  input  logic                   i_ex_rd_wen,
  input  logic [4:0]             i_ex_rd_addr,
  input  logic                   i_ex_is_load,
  input  logic [XLEN-1:0]        i_ex_rd_data,
  input  logic                   i_mem_rd_wen,
  input  logic [4:0]             i_mem_rd_addr,
  input  logic [XLEN-1:0]        i_mem_rd_data,
  output logic                   o_ex_valid,
  output logic [XLEN-1:0]        o_ex_pc,
  output logic [XLEN-1:0]        o_ex_rs1_data,
  output logic [XLEN-1:0]        o_ex_rs2_data,
  output logic [XLEN-1:0]        o_ex_imm,
  output logic [3:0]             o_ex_alu_op,
  output logic                   o_ex_src_imm,
  output logic                   o_ex_src_pc,
  output logic                   o_ex_link,
  output logic [2:0]             o_ex_funct3,
  output logic                   o_ex_mem_rd,
  output logic                   o_ex_mem_wr,
  output logic [4:0]             o_ex_rd_addr,
  output logic                   o_ex_rd_wen
);
  ctrl_t           ctrl, ex_ctrl;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] imm, rs1_data, rs2_data, jalr_sum, ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic            use_rs1, use_rs2, eq, lt, ltu, taken, bubble;
  assign op = i_if_instr[6:0];
  assign f3 = i_if_instr[14:12];
  assign rs1 = i_if_instr[19:15];
  assign rs2 = i_if_instr[24:20];
  assign ctrl = decode(i_if_instr[31:0]);
  nnrv_imm_gen #(.XLEN(XLEN)) u_imm (.instr(i_if_instr[31:0]), .imm(imm));
  assign o_rf_rs1_addr = rs1;
  assign o_rf_rs2_addr = rs2;
  assign rs1_data = rs1 == 5'd0 ? '0 :
                    i_ex_rd_wen && !i_ex_is_load && i_ex_rd_addr == rs1 ? i_ex_rd_data :
                    i_mem_rd_wen && i_mem_rd_addr == rs1 ? i_mem_rd_data : i_rf_rs1_data;
  assign rs2_data = rs2 == 5'd0 ? '0 :
                    i_ex_rd_wen && !i_ex_is_load && i_ex_rd_addr == rs2 ? i_ex_rd_data :
                    i_mem_rd_wen && i_mem_rd_addr == rs2 ? i_mem_rd_data : i_rf_rs2_data;
  assign use_rs1 = op inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
  assign use_rs2 = op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  assign o_if_hazard_stall = i_ex_is_load && i_ex_rd_wen && i_ex_rd_addr != 5'd0 &&
                             (use_rs1 && i_ex_rd_addr == rs1 || use_rs2 && i_ex_rd_addr == rs2);
  assign eq = rs1_data == rs2_data;
  assign lt = $signed(rs1_data) < $signed(rs2_data);
  assign ltu = rs1_data < rs2_data;
  assign taken = op == OPC_BRANCH &&
                 (f3 == BR_EQ ? eq : f3 == BR_NE ? !eq : f3 == BR_LT ? lt :
                  f3 == BR_GE ? !lt : f3 == BR_LTU ? ltu : f3 == BR_GEU && !ltu);
  assign jalr_sum = rs1_data + imm;
  assign o_if_jmp_stall = !o_if_hazard_stall && (op == OPC_JAL || op == OPC_JALR || taken);
  assign o_if_jmp_pc = op == OPC_JALR ? {jalr_sum[XLEN-1:1], 1'b0} : i_if_cur_pc + imm;
  assign bubble = o_if_hazard_stall || !ctrl.valid;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      ex_ctrl <= '0;
      ex_pc <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_imm <= '0;
    end else begin
      ex_ctrl <= bubble ? '0 : ctrl;
      ex_pc <= bubble ? '0 : i_if_cur_pc;
      ex_rs1 <= bubble ? '0 : rs1_data;
      ex_rs2 <= bubble ? '0 : rs2_data;
      ex_imm <= bubble ? '0 : imm;
    end
  assign o_ex_valid = ex_ctrl.valid;
  assign o_ex_pc = ex_pc;
  assign o_ex_rs1_data = ex_rs1;
  assign o_ex_rs2_data = ex_rs2;
  assign o_ex_imm = ex_imm;
  assign o_ex_alu_op = ex_ctrl.alu_op;
  assign o_ex_src_imm = ex_ctrl.src_imm;
  assign o_ex_src_pc = ex_ctrl.src_pc;
  assign o_ex_link = ex_ctrl.link;
  assign o_ex_funct3 = ex_ctrl.funct3;
  assign o_ex_mem_rd = ex_ctrl.mem_rd;
  assign o_ex_mem_wr = ex_ctrl.mem_wr;
  assign o_ex_rd_addr = ex_ctrl.rd_addr;
  assign o_ex_rd_wen = ex_ctrl.rd_wen;
endmodule

// File: tb/tb_nnrv_id.sv
// tb_nnrv_id: table-driven directed vectors plus hazard-replay and async-reset sequences for nnrv_id
`timescale 1ns/1ps
module tb_nnrv_id;
  logic        clk, rst;
  logic [31:0] instr, pc, rf1, rf2, exd, md;
  logic        exw, exl, mw;
  logic [4:0]  exa, ma;
  logic        jmp, hz;
  logic [31:0] jpc;
  logic [4:0]  ra1, ra2;
  logic        ev, elink, esrci, esrcp, emrd, emwr, ewen;
  logic [31:0] epc, ed1, ed2, eimm;
  logic [3:0]  ealu;
  logic [2:0]  ef3;
  logic [4:0]  erd;
  int checks = 0, errors = 0, vid = 0;
  typedef struct packed {
    logic [31:0] ins, pc, rf1, rf2;
    logic        exw, exl;
    logic [4:0]  exa;
    logic [31:0] exd;
    logic        mw;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        hz, jmp;
    logic [31:0] jpc;
    logic        v, wen, link, mrd, mwr, ca, ci, srci, srcp;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [31:0] imm, d1, d2;
  } vec_t;
  vec_t tv[$];
  vec_t t;
  nnrv_id dut (
    .i_clk(clk), .i_rst(rst), .i_if_instr(instr), .i_if_cur_pc(pc),
    .o_if_jmp_stall(jmp), .o_if_jmp_pc(jpc), .o_if_hazard_stall(hz),
    .o_rf_rs1_addr(ra1), .o_rf_rs2_addr(ra2), .i_rf_rs1_data(rf1), .i_rf_rs2_data(rf2),
    .i_ex_rd_wen(exw), .i_ex_rd_addr(exa), .i_ex_is_load(exl), .i_ex_rd_data(exd),
    .i_mem_rd_wen(mw), .i_mem_rd_addr(ma), .i_mem_rd_data(md),
    .o_ex_valid(ev), .o_ex_pc(epc), .o_ex_rs1_data(ed1), .o_ex_rs2_data(ed2),
    .o_ex_imm(eimm), .o_ex_alu_op(ealu), .o_ex_src_imm(esrci), .o_ex_src_pc(esrcp),
    .o_ex_link(elink), .o_ex_funct3(ef3), .o_ex_mem_rd(emrd), .o_ex_mem_wr(emwr),
    .o_ex_rd_addr(erd), .o_ex_rd_wen(ewen)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] im, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(logic [19:0] im, logic [4:0] rd, logic [6:0] op);
    return {im, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] im, logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
  endfunction
  function automatic vec_t nv(logic [31:0] ins, logic [31:0] p);
    vec_t r;
    r = '0;
    r.ins = ins;
    r.pc = p;
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec %0d %s: got %h expected %h", vid, nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    @(negedge clk);
    instr = v.ins; pc = v.pc; rf1 = v.rf1; rf2 = v.rf2;
    exw = v.exw; exl = v.exl; exa = v.exa; exd = v.exd;
    mw = v.mw; ma = v.ma; md = v.md;
    #1;
    chk("rs1_addr", 32'(ra1), 32'(v.ins[19:15]));
    chk("rs2_addr", 32'(ra2), 32'(v.ins[24:20]));
    chk("hazard_stall", 32'(hz), 32'(v.hz));
    chk("jmp_stall", 32'(jmp), 32'(v.jmp));
    if (v.jmp) chk("jmp_pc", jpc, v.jpc);
    @(posedge clk);
    #1;
    chk("ex_valid", 32'(ev), 32'(v.v));
    chk("ex_rd_wen", 32'(ewen), 32'(v.wen));
    chk("ex_mem_rd", 32'(emrd), 32'(v.mrd));
    chk("ex_mem_wr", 32'(emwr), 32'(v.mwr));
    chk("ex_link", 32'(elink), 32'(v.link));
    if (v.v) begin
      chk("ex_pc", epc, v.pc);
      chk("ex_rs1_data", ed1, v.d1);
      chk("ex_rs2_data", ed2, v.d2);
      if (v.ci) chk("ex_imm", eimm, v.imm);
      if (v.wen) chk("ex_rd_addr", 32'(erd), 32'(v.rd));
      if (v.ca) begin
        chk("ex_alu_op", 32'(ealu), 32'(v.alu));
        chk("ex_src_imm", 32'(esrci), 32'(v.srci));
        chk("ex_src_pc", 32'(esrcp), 32'(v.srcp));
      end
    end
    vid++;
  endtask
  initial begin
    rst = 1; instr = 0; pc = 0; rf1 = 0; rf2 = 0; exw = 0; exl = 0; exa = 0; exd = 0;
    mw = 0; ma = 0; md = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ev), 0);
    chk("rst_rd_wen", 32'(ewen), 0);
    chk("rst_pc", epc, 0);
    chk("rst_imm", eimm, 0);
    chk("rst_alu", 32'(ealu), 0);
    chk("rst_jmp", 32'(jmp), 0);
    chk("rst_hazard", 32'(hz), 0);
    @(negedge clk);
    rst = 0;
    t = nv(32'h0, 32'h0); tv.push_back(t);
    t = nv(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h10); t.rf1 = 32'h55;
    t.v = 1; t.wen = 1; t.rd = 1; t.imm = 5; t.ci = 1; t.ca = 1; t.alu = 0; t.srci = 1; tv.push_back(t);
    t = nv(enc_r(7'h20, 5'd7, 5'd6, 3'd0, 5'd5), 32'h14); t.rf1 = 1; t.rf2 = 3;
    t.exw = 1; t.exa = 6; t.exd = 32'hAAAA; t.mw = 1; t.ma = 6; t.md = 32'hBBBB;
    t.v = 1; t.wen = 1; t.rd = 5; t.d1 = 32'hAAAA; t.d2 = 3; t.ca = 1; t.alu = 1; tv.push_back(t);
    t = nv(enc_r(7'h0, 5'd0, 5'd0, 3'd0, 5'd4), 32'h18); t.rf1 = 32'h77; t.rf2 = 32'h77;
    t.exw = 1; t.exl = 1; t.exa = 0; t.v = 1; t.wen = 1; t.rd = 4; t.ca = 1; tv.push_back(t);
    t = nv(enc_i(12'd1, 5'd2, 3'd0, 5'd1, 7'h13), 32'h1C); t.rf1 = 5;
    t.exw = 1; t.exl = 1; t.exa = 1; t.exd = 32'hDEAD;
    t.v = 1; t.wen = 1; t.rd = 1; t.imm = 1; t.ci = 1; t.d1 = 5; t.ca = 1; t.srci = 1; tv.push_back(t);
    t = nv(enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'h13), 32'h20); t.rf1 = 9;
    t.v = 1; t.d1 = 9; t.imm = 1; t.ci = 1; tv.push_back(t);
    t = nv(enc_u(20'h12345, 5'd2, 7'h37), 32'h24);
    t.v = 1; t.wen = 1; t.rd = 2; t.imm = 32'h12345000; t.ci = 1; t.ca = 1; t.alu = 10; t.srci = 1; tv.push_back(t);
    t = nv(enc_u(20'h1, 5'd3, 7'h17), 32'h40);
    t.v = 1; t.wen = 1; t.rd = 3; t.imm = 32'h1000; t.ci = 1; t.ca = 1; t.srci = 1; t.srcp = 1; tv.push_back(t);
    t = nv(enc_i(12'hFFC, 5'd1, 3'd2, 5'd3, 7'h03), 32'h44); t.rf1 = 32'h100;
    t.v = 1; t.wen = 1; t.rd = 3; t.mrd = 1; t.imm = 32'hFFFFFFFC; t.ci = 1; t.d1 = 32'h100;
    t.ca = 1; t.srci = 1; tv.push_back(t);
    t = nv(enc_s(12'd8, 5'd2, 5'd1, 3'd2), 32'h48); t.rf1 = 32'h200; t.rf2 = 32'h55;
    t.v = 1; t.mwr = 1; t.imm = 8; t.ci = 1; t.d1 = 32'h200; t.d2 = 32'h55; t.ca = 1; t.srci = 1; tv.push_back(t);
    t = nv(enc_i(12'h403, 5'd2, 3'd5, 5'd1, 7'h13), 32'h4C); t.rf1 = 32'h80;
    t.v = 1; t.wen = 1; t.rd = 1; t.imm = 32'h403; t.ci = 1; t.d1 = 32'h80; t.ca = 1; t.alu = 7; t.srci = 1; tv.push_back(t);
    t = nv(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h20); t.rf1 = 99; t.rf2 = 7; t.exw = 1; t.exa = 1; t.exd = 7;
    t.jmp = 1; t.jpc = 32'h28; t.v = 1; t.imm = 8; t.ci = 1; t.d1 = 7; t.d2 = 7; tv.push_back(t);
    t.rf2 = 6; t.jmp = 0; t.d2 = 6; tv.push_back(t);
    t = nv(enc_i(12'd12, 5'd5, 3'd0, 5'd1, 7'h67), 32'h30); t.mw = 1; t.ma = 5; t.md = 32'h101;
    t.jmp = 1; t.jpc = 32'h10C; t.v = 1; t.wen = 1; t.rd = 1; t.link = 1; t.imm = 12; t.ci = 1; t.d1 = 32'h101; tv.push_back(t);
    t = nv(enc_b(13'h1FF0, 5'd2, 5'd1, 3'd4), 32'h100); t.rf1 = 32'hFFFFFFFF; t.rf2 = 1;
    t.jmp = 1; t.jpc = 32'hF0; t.v = 1; t.imm = 32'hFFFFFFF0; t.ci = 1; t.d1 = 32'hFFFFFFFF; t.d2 = 1; tv.push_back(t);
    t.ins = enc_b(13'h1FF0, 5'd2, 5'd1, 3'd6); t.jmp = 0; tv.push_back(t);
    t.ins = enc_b(13'h1FF0, 5'd2, 5'd1, 3'd5); t.rf1 = 1; t.rf2 = 32'hFFFFFFFF;
    t.jmp = 1; t.d1 = 1; t.d2 = 32'hFFFFFFFF; tv.push_back(t);
    t.ins = enc_b(13'h1FF0, 5'd2, 5'd1, 3'd1); t.rf1 = 5; t.rf2 = 5; t.jmp = 0; t.d1 = 5; t.d2 = 5; tv.push_back(t);
    t = nv(enc_j(21'h800, 5'd1), 32'hFFFFF800);
    t.jmp = 1; t.jpc = 32'h0; t.v = 1; t.wen = 1; t.rd = 1; t.link = 1; t.imm = 32'h800; t.ci = 1; tv.push_back(t);
    t = nv(32'h0000007F, 32'h60); tv.push_back(t);
    t = nv(enc_s(12'd0, 5'd3, 5'd1, 3'd2), 32'h64); t.exw = 1; t.exl = 1; t.exa = 3; t.hz = 1; tv.push_back(t);
    t = nv(enc_i(12'd0, 5'd5, 3'd0, 5'd1, 7'h67), 32'h68); t.exw = 1; t.exl = 1; t.exa = 5; t.hz = 1; tv.push_back(t);
    foreach (tv[i]) run(tv[i]);
    t = nv(enc_r(7'h0, 5'd2, 5'd3, 3'd0, 5'd4), 32'h50); t.rf2 = 20;
    t.exw = 1; t.exl = 1; t.exa = 3; t.exd = 32'hDEAD; t.hz = 1; run(t);
    t = nv(enc_r(7'h0, 5'd2, 5'd3, 3'd0, 5'd4), 32'h50); t.rf2 = 20; t.mw = 1; t.ma = 3; t.md = 32'h33;
    t.v = 1; t.wen = 1; t.rd = 4; t.d1 = 32'h33; t.d2 = 20; t.ca = 1; run(t);
    t = nv(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h20); t.rf1 = 7; t.rf2 = 7;
    t.exw = 1; t.exl = 1; t.exa = 1; t.hz = 1; run(t);
    t = nv(enc_b(13'd8, 5'd2, 5'd1, 3'd0), 32'h20); t.rf2 = 7; t.mw = 1; t.ma = 1; t.md = 7;
    t.jmp = 1; t.jpc = 32'h28; t.v = 1; t.imm = 8; t.ci = 1; t.d1 = 7; t.d2 = 7; run(t);
    t = nv(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 32'h10);
    t.v = 1; t.wen = 1; t.rd = 1; t.imm = 5; t.ci = 1; run(t);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 32'(ev), 0);
    chk("async_rst_rd_wen", 32'(ewen), 0);
    chk("async_rst_pc", epc, 0);
    @(negedge clk);
    rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
